// File: rtl/nnrv_mmio_uart_tx_if.sv
// nnrv_mmio_uart_tx_if
//   Memory-stage data port bundle (same rd/wr addr/en/mask/data signalling
//   as the RAM port) used to reach the memory-mapped UART transmitter.
//   master : mem stage (drives requests, receives read data)
//   slave  : responder (UART)
//   Signals: i_rd_addr, i_rd_en, i_rd_mask, o_rd_data (combinational),
//            i_wr_addr, i_wr_en, i_wr_mask, i_wr_data
interface nnrv_mmio_uart_tx_if #(
   parameter int XLEN       = 64,
   parameter int ADDR_WIDTH = 8,
   parameter int MASK_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic                  i_rd_en;
   logic [MASK_WIDTH-1:0] i_rd_mask;
   logic [XLEN-1:0]       o_rd_data;
   logic [ADDR_WIDTH-1:0] i_wr_addr;
   logic                  i_wr_en;
   logic [MASK_WIDTH-1:0] i_wr_mask;
   logic [XLEN-1:0]       i_wr_data;

   modport master (
      output i_rd_addr, i_rd_en, i_rd_mask,
      input  o_rd_data,
      output i_wr_addr, i_wr_en, i_wr_mask, i_wr_data
   );

   modport slave (
      input  i_rd_addr, i_rd_en, i_rd_mask,
      output o_rd_data,
      input  i_wr_addr, i_wr_en, i_wr_mask, i_wr_data
   );
endinterface

// File: rtl/nnrv_mmio_uart_tx.sv
// nnrv_mmio_uart_tx
//   Memory-mapped UART transmitter on the mem stage's data port. Bytes
//   written to TXDATA enter a small TX FIFO; a bit-serial FSM shifts them
//   out on o_tx (8N1, LSB first, idle high). STATUS and DIV are readable.
//   Register window (offset from BASE_ADDR):
//     0x00 TXDATA (W)     push wr_data[7:0] when wr_mask[0]
//     0x08 STATUS (R/W1C) [0] empty [1] full [2] busy [3] overflow [7:4] count
//     0x10 DIV    (R/W)   [15:0] bit period = DIV+1 clocks
// Ports
//   i_clk   clock
//   i_rst   asynchronous active-low reset
//   bus     data port (slave modport of nnrv_mmio_uart_tx_if)
//   o_tx    serial line, idle high
//   o_busy  shifter not IDLE (registered with the state)
// Configuration
//   NNRV_UART_PARITY_EN : adds an even-parity bit between data and stop
//                         (11-bit frame); undefined gives plain 8N1.
module nnrv_mmio_uart_tx #(
   parameter int                    XLEN       = 64,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    MASK_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'hC0,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [15:0]           DIV_RESET  = 16'd433
) (
   input  logic                i_clk,
   input  logic                i_rst,
   nnrv_mmio_uart_tx_if.slave  bus,
   output logic                o_tx,
   output logic                o_busy
);

   localparam int                    PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0]            FULL_CNT = 4'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] A_TXDATA = BASE_ADDR;
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = BASE_ADDR + ADDR_WIDTH'(8);
   localparam logic [ADDR_WIDTH-1:0] A_DIV    = BASE_ADDR + ADDR_WIDTH'(16);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     div_q;
   logic [15:0]     cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            busy_q;
   logic            tick;

   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [3:0]      count;
   logic            full, empty;
   logic            push, pop;
   logic            ovf_q;

   logic            wr_txdata, wr_status_clr, wr_div;
   logic [XLEN-1:0] rd_data;

`ifdef NNRV_UART_PARITY_EN
   logic            par_q, par_d;
`endif

   // bits the port carries but this block never looks at
   wire unused = &{1'b0, bus.i_rd_mask, bus.i_wr_data[XLEN-1:16],
                   bus.i_wr_mask[MASK_WIDTH-1:2]};

   // ---------------- write decode ----------------
   assign wr_txdata     = bus.i_wr_en && (bus.i_wr_addr == A_TXDATA) && bus.i_wr_mask[0];
   assign wr_status_clr = bus.i_wr_en && (bus.i_wr_addr == A_STATUS) && bus.i_wr_mask[0]
                          && bus.i_wr_data[3];
   assign wr_div        = bus.i_wr_en && (bus.i_wr_addr == A_DIV);

   // ---------------- TX FIFO ----------------
   assign full  = (count == FULL_CNT);
   assign empty = (count == 4'd0);
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push  = wr_txdata && (!full || pop);

   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.i_wr_data[7:0];
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 4'd0;
         ovf_q  <= 1'b0;
         div_q  <= DIV_RESET;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: ;
         endcase
         if (wr_txdata && !push) ovf_q <= 1'b1;
         else if (wr_status_clr) ovf_q <= 1'b0;
         if (wr_div) begin
            if (bus.i_wr_mask[0]) div_q[7:0]  <= bus.i_wr_data[7:0];
            if (bus.i_wr_mask[1]) div_q[15:8] <= bus.i_wr_data[15:8];
         end
      end
   end

   // ---------------- shifter FSM ----------------
   // cnt is reloaded from DIV at every bit boundary, so DIV writes only
   // affect the next bit.
   assign tick = (cnt_q == 16'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef NNRV_UART_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != S_IDLE && !tick) cnt_d = cnt_q - 16'd1;

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr];
`ifdef NNRV_UART_PARITY_EN
               par_d   = ^fifo_mem[rd_ptr];
`endif
               cnt_d   = div_q;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               cnt_d   = div_q;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               cnt_d   = div_q;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef NNRV_UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef NNRV_UART_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               cnt_d   = div_q;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               // back-to-back frames: no idle bit between stop and start
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr];
`ifdef NNRV_UART_PARITY_EN
                  par_d   = ^fifo_mem[rd_ptr];
`endif
                  cnt_d   = div_q;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         busy_q  <= 1'b0;
`ifdef NNRV_UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         busy_q  <= (state_d != S_IDLE);
`ifdef NNRV_UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // o_tx decodes straight from the state register, so reset forces the
   // line high without waiting for a clock.
   always_comb begin
      o_tx = 1'b1;
      case (state_q)
         S_START: o_tx = 1'b0;
         S_DATA:  o_tx = shift_q[0];
`ifdef NNRV_UART_PARITY_EN
         S_PARITY: o_tx = par_q;
`endif
         default: o_tx = 1'b1;
      endcase
   end

   assign o_busy = busy_q;

   // ---------------- read mux ----------------
   always_comb begin
      rd_data = '0;
      if (bus.i_rd_en) begin
         if (bus.i_rd_addr == A_STATUS)
            rd_data[7:0] = {count, ovf_q, busy_q, full, empty};
         else if (bus.i_rd_addr == A_DIV)
            rd_data[15:0] = div_q;
      end
   end

   assign bus.o_rd_data = rd_data;

endmodule

// File: tb/tb_nnrv_mmio_uart_tx.sv
// tb_nnrv_mmio_uart_tx
//   Self-checking bench: a register vector table, a serial-line monitor that
//   pops expected bytes from a scoreboard queue and checks every bit cell,
//   and hand-written sequences for FIFO overflow, W1C, mask gating and reset.
module tb_nnrv_mmio_uart_tx;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   logic o_tx, o_busy;

   always #5 i_clk = ~i_clk;

   nnrv_mmio_uart_tx_if #(.XLEN(64), .ADDR_WIDTH(8), .MASK_WIDTH(8)) bus ();

   nnrv_mmio_uart_tx #(
      .XLEN(64), .ADDR_WIDTH(8), .MASK_WIDTH(8), .BASE_ADDR(8'hC0),
      .FIFO_DEPTH(4), .DIV_RESET(16'd433)
   ) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .bus    (bus.slave),
      .o_tx   (o_tx),
      .o_busy (o_busy)
   );

`ifdef NNRV_UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int BIT_CLKS = 4;   // DIV=3 once programmed

   int checks = 0;
   int passes = 0;

   logic [7:0] exp_q [$];
   int         gaps [$];
   int         idle_run = 0;
   int         rx_frames = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] m);
      @(negedge i_clk);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d; bus.i_wr_mask = m;
      @(negedge i_clk);
      bus.i_wr_en = 1'b0; bus.i_wr_mask = 8'h00;
   endtask

   task automatic rd(input logic en, input logic [7:0] a, output logic [63:0] d);
      bus.i_rd_en = en; bus.i_rd_addr = a; bus.i_rd_mask = 8'hFF;
      #1;
      d = bus.o_rd_data;
      bus.i_rd_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((o_busy || exp_q.size() != 0) && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      chk(name, 64'(n < budget), 64'd1);
      repeat (2) @(negedge i_clk);
   endtask

   // Serial monitor: on a start bit, pop the expected byte and compare the
   // line on every clock of the frame; the byte is also recovered from
   // mid-bit samples.
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst && o_tx == 1'b0) begin
            gaps.push_back(idle_run);
            idle_run = 0;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 64'd1, 64'd0);
            end else begin
               logic [7:0]  b;
               logic [7:0]  rx;
               logic [10:0] bits;
               bit ok, ab;
               b = exp_q.pop_front();
               bits = '1;
               bits[0] = 1'b0;
               for (int j = 0; j < 8; j++) bits[1+j] = b[j];
`ifdef NNRV_UART_PARITY_EN
               bits[9] = ^b;
`endif
               bits[FB-1] = 1'b1;
               ok = 1'b1; ab = 1'b0; rx = 8'h00;
               for (int k = 0; k < FB && !ab; k++) begin
                  for (int c = 0; c < BIT_CLKS && !ab; c++) begin
                     if (!(k == 0 && c == 0)) @(negedge i_clk);
                     if (!i_rst) ab = 1'b1;
                     else begin
                        if (o_tx !== bits[k]) ok = 1'b0;
                        if (c == 1 && k >= 1 && k <= 8) rx[k-1] = o_tx;
                     end
                  end
               end
               if (!ab) begin
                  rx_frames++;
                  chk("frame_bits", 64'(ok), 64'd1);
                  chk("rx_byte", 64'(rx), 64'(b));
               end
            end
         end else begin
            idle_run++;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   typedef struct {
      logic        wen;
      logic [7:0]  waddr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic        ren;
      logic [7:0]  raddr;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [63:0] d;
      int hb, frames0, gsum;

      vecs[0] = '{1'b0, 8'h00, 64'h0,    8'h00, 1'b1, 8'hC8, 64'h01};       // STATUS reset
      vecs[1] = '{1'b0, 8'h00, 64'h0,    8'h00, 1'b1, 8'hD0, 64'd433};      // DIV reset
      vecs[2] = '{1'b0, 8'h00, 64'h0,    8'h00, 1'b1, 8'hD8, 64'h0};        // unmapped
      vecs[3] = '{1'b0, 8'h00, 64'h0,    8'h00, 1'b0, 8'hD0, 64'h0};        // rd_en=0
      vecs[4] = '{1'b1, 8'hD0, 64'h1234, 8'h02, 1'b1, 8'hD0, 64'h12B1};     // hi byte only
      vecs[5] = '{1'b1, 8'hD0, 64'hFFFF, 8'h00, 1'b1, 8'hD0, 64'h12B1};     // no lanes
      vecs[6] = '{1'b1, 8'hD0, 64'h0003, 8'h01, 1'b1, 8'hD0, 64'h1203};     // lo byte only
      vecs[7] = '{1'b1, 8'hD0, 64'h0003, 8'h03, 1'b1, 8'hD0, 64'h0003};     // DIV=3
      vecs[8] = '{1'b1, 8'hD8, 64'hFF,   8'hFF, 1'b1, 8'hD8, 64'h0};        // unmapped write
      vecs[9] = '{1'b1, 8'hC8, 64'hFF,   8'hFF, 1'b1, 8'hC8, 64'h01};       // W1C, nothing set

      bus.i_rd_addr = 8'h00; bus.i_rd_en = 1'b0; bus.i_rd_mask = 8'h00;
      bus.i_wr_addr = 8'h00; bus.i_wr_en = 1'b0; bus.i_wr_mask = 8'h00;
      bus.i_wr_data = 64'h0;

      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);

      chk("reset_tx", 64'(o_tx), 64'd1);
      chk("reset_busy", 64'(o_busy), 64'd0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wen) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
         rd(vecs[i].ren, vecs[i].raddr, d);
         chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      // single frame 0x55: latency, busy length, line contents via monitor
      frames0 = rx_frames;
      exp_q.push_back(8'h55);
      wr(8'hC0, 64'h55, 8'h01);
      chk("lat_tx_hi", 64'(o_tx), 64'd1);
      chk("lat_busy_lo", 64'(o_busy), 64'd0);
      @(negedge i_clk);
      chk("start_tx", 64'(o_tx), 64'd0);
      hb = 0;
      for (int i = 0; i < 100 && o_busy; i++) begin
         hb++;
         @(negedge i_clk);
      end
      chk("busy_len", 64'(hb), 64'(BIT_CLKS * FB));
      wait_idle(50, "frame55_done");
      chk("frame55_rx", 64'(rx_frames - frames0), 64'd1);
      rd(1'b1, 8'hC8, d);
      chk("status_after55", d, 64'h01);

      // burst of six: one shifting, four queued, one dropped
      frames0 = rx_frames;
      gaps.delete();
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'hA0 + 8'(i));
      for (int i = 1; i <= 6; i++) begin
         @(negedge i_clk);
         bus.i_wr_en = 1'b1; bus.i_wr_addr = 8'hC0;
         bus.i_wr_data = 64'hA0 + 64'(i); bus.i_wr_mask = 8'h01;
      end
      @(negedge i_clk);
      bus.i_wr_en = 1'b0; bus.i_wr_mask = 8'h00;
      rd(1'b1, 8'hC8, d);
      chk("status_burst", d, 64'h4E);
      wr(8'hC8, 64'h08, 8'h01);
      rd(1'b1, 8'hC8, d);
      chk("status_w1c", d, 64'h46);
      wait_idle(600, "burst_done");
      chk("burst_rx", 64'(rx_frames - frames0), 64'd5);
      gsum = 0;
      for (int i = 1; i < gaps.size(); i++) gsum += gaps[i];
      chk("burst_gaps_n", 64'(gaps.size()), 64'd5);
      chk("burst_no_gap", 64'(gsum), 64'd0);
      rd(1'b1, 8'hC8, d);
      chk("status_after_burst", d, 64'h01);

`ifdef NNRV_UART_PARITY_EN
      frames0 = rx_frames;
      exp_q.push_back(8'h07);
      wr(8'hC0, 64'h07, 8'h01);
      @(negedge i_clk);
      hb = 0;
      for (int i = 0; i < 100 && o_busy; i++) begin
         hb++;
         @(negedge i_clk);
      end
      chk("parity_busy_len", 64'(hb), 64'd44);
      wait_idle(50, "parity_done");
      chk("parity_rx", 64'(rx_frames - frames0), 64'd1);
`endif

      // TXDATA write without lane 0: no push
      wr(8'hC0, 64'h5A, 8'hFE);
      repeat (3) @(negedge i_clk);
      chk("nomask_tx", 64'(o_tx), 64'd1);
      chk("nomask_busy", 64'(o_busy), 64'd0);
      rd(1'b1, 8'hC8, d);
      chk("nomask_status", d, 64'h01);

      // reset in the middle of a data bit that drives 0
      exp_q.push_back(8'h55);
      wr(8'hC0, 64'h55, 8'h01);
      repeat (10) @(negedge i_clk);
      chk("pre_reset_tx", 64'(o_tx), 64'd0);
      #2 i_rst = 1'b0;
      #1;
      chk("async_reset_tx", 64'(o_tx), 64'd1);
      chk("async_reset_busy", 64'(o_busy), 64'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      exp_q.delete();
      @(negedge i_clk);
      rd(1'b1, 8'hC8, d);
      chk("post_reset_status", d, 64'h01);
      rd(1'b1, 8'hD0, d);
      chk("post_reset_div", d, 64'd433);
      repeat (5) @(negedge i_clk);
      chk("post_reset_tx", 64'(o_tx), 64'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
